// File: rtl/vga_pkg.sv
// ---------------------------------------------------------------------------
// vga_pkg
// Shared constants for the VGA pixel-RAM arbiter.
//   ADDR_W_DEF / DATA_W_DEF : default pixel address / pixel data widths
//   RD_LAT                  : display read latency, address edge to rd_valid
//   GNT_*                   : encoding of the arbiter's grant output
// ---------------------------------------------------------------------------
package vga_pkg;
   localparam int ADDR_W_DEF = 15;
   localparam int DATA_W_DEF = 6;
   localparam int RD_LAT     = 2;

   localparam logic [1:0] GNT_IDLE  = 2'd0;
   localparam logic [1:0] GNT_READ  = 2'd1;
   localparam logic [1:0] GNT_WRITE = 2'd2;

   // Grant FSM state doubles as the grant output, so it uses the same codes.
   typedef enum logic [1:0] {
      ST_IDLE  = GNT_IDLE,
      ST_READ  = GNT_READ,
      ST_WRITE = GNT_WRITE
   } gnt_state_e;
endpackage

// File: rtl/arb_wr_fifo.sv
// ---------------------------------------------------------------------------
// arb_wr_fifo
// Synchronous write buffer holding {addr,data} pixel entries.
//   clk, reset_n : clock, asynchronous active-low reset
//   push, din    : enqueue one entry (caller guarantees not full)
//   pop, dout    : dequeue head (caller guarantees not empty); dout is the
//                  current head, available combinationally
//   full, empty  : registered flags, consistent with count after each edge
//   count        : number of stored entries
// ---------------------------------------------------------------------------
module arb_wr_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 21
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     push,
   input  logic                     pop,
   input  logic [W-1:0]             din,
   output logic [W-1:0]             dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [W-1:0]  r_mem [DEPTH];
   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;
   logic          r_full;
   logic          r_empty;
   logic [CW-1:0] w_count_next;

   always_comb begin
      w_count_next = r_count;
      if (push && !pop)
         w_count_next = r_count + 1'b1;
      else if (!push && pop)
         w_count_next = r_count - 1'b1;
   end

   // Storage needs no reset; only pointers and flags define validity.
   always_ff @(posedge clk) begin
      if (push)
         r_mem[r_wr_ptr] <= din;
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_full   <= 1'b0;
         r_empty  <= 1'b1;
      end else begin
         if (push)
            r_wr_ptr <= r_wr_ptr + 1'b1;
         if (pop)
            r_rd_ptr <= r_rd_ptr + 1'b1;
         r_count <= w_count_next;
         r_full  <= (w_count_next == FULL_CNT);
         r_empty <= (w_count_next == '0);
      end
   end

   assign dout  = r_mem[r_rd_ptr];
   assign full  = r_full;
   assign empty = r_empty;
   assign count = r_count;
endmodule

// File: rtl/vga_ram_arbiter.sv
// ---------------------------------------------------------------------------
// vga_ram_arbiter
// Shares a single-port pixel RAM (1-cycle read latency) between the VGA
// scan-out reader and a buffered pixel writer. Display reads always win;
// buffered writes drain only in cycles with no display read.
//   clk, reset_n             : pixel clock, asynchronous active-low reset
//   rd_en, rd_addr           : display read request / address
//   rd_data, rd_valid        : read return, RD_LAT cycles after the request
//   wr_req, wr_addr, wr_data : writer offers one pixel, held until wr_ack
//   wr_ack                   : one-cycle pulse, pixel accepted into buffer
//   wr_full, wr_empty        : write buffer status
//   ram_addr/ram_we/ram_wdata: registered RAM port; ram_q is RAM read data
//   grant                    : last issued op (GNT_IDLE/GNT_READ/GNT_WRITE)
// Optional build macro ARB_STATS_EN adds:
//   stall_cnt : saturating count of edges where a buffered write was blocked
//   ovf_seen  : sticky flag, wr_req observed while the buffer was full
// ---------------------------------------------------------------------------
module vga_ram_arbiter
   import vga_pkg::*;
#(
   parameter int ADDR_W     = ADDR_W_DEF,
   parameter int DATA_W     = DATA_W_DEF,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   input  logic              wr_req,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   output logic              wr_ack,
   output logic              wr_full,
   output logic              wr_empty,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_we,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_q,
   output logic [1:0]        grant
`ifdef ARB_STATS_EN
   ,
   output logic [15:0]       stall_cnt,
   output logic              ovf_seen
`endif
);
   localparam int EW = ADDR_W + DATA_W;
   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   logic [EW-1:0]     w_head;
   logic              w_full;
   logic              w_empty;
   logic [CW-1:0]     w_count;
   logic              w_has_data;
   logic              w_push;
   logic              w_pop;

   gnt_state_e        r_state;
   logic [ADDR_W-1:0] r_ram_addr;
   logic              r_ram_we;
   logic [DATA_W-1:0] r_ram_wdata;
   logic              r_wr_ack;
   logic [RD_LAT-1:0] r_rd_pipe;
   logic              r_rd_valid;
   logic [DATA_W-1:0] r_rd_data;

   // A full buffer refuses the push even if a pop frees a slot this edge.
   // Pop uses the pre-edge count, so a pixel pushed into an empty buffer
   // reaches RAM one edge later at the earliest.
   assign w_has_data = (w_count != '0);
   assign w_push     = wr_req && !w_full;
   assign w_pop      = !rd_en && w_has_data;

   arb_wr_fifo #(
      .DEPTH (FIFO_DEPTH),
      .W     (EW)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (w_push),
      .pop     (w_pop),
      .din     ({wr_addr, wr_data}),
      .dout    (w_head),
      .full    (w_full),
      .empty   (w_empty),
      .count   (w_count)
   );

   // Grant FSM with registered RAM port. IDLE holds address and data.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= ST_IDLE;
         r_ram_addr  <= '0;
         r_ram_we    <= 1'b0;
         r_ram_wdata <= '0;
         r_wr_ack    <= 1'b0;
      end else begin
         r_wr_ack <= w_push;
         if (rd_en) begin
            r_state    <= ST_READ;
            r_ram_addr <= rd_addr;
            r_ram_we   <= 1'b0;
         end else if (w_pop) begin
            r_state     <= ST_WRITE;
            r_ram_addr  <= w_head[EW-1:DATA_W];
            r_ram_wdata <= w_head[DATA_W-1:0];
            r_ram_we    <= 1'b1;
         end else begin
            r_state  <= ST_IDLE;
            r_ram_we <= 1'b0;
         end
      end
   end

   // Read return pipeline: address registered at edge N, RAM data out after
   // N+1, captured into rd_data at N+RD_LAT.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_rd_pipe  <= '0;
         r_rd_valid <= 1'b0;
         r_rd_data  <= '0;
      end else begin
         r_rd_pipe  <= {r_rd_pipe[RD_LAT-2:0], rd_en};
         r_rd_valid <= r_rd_pipe[RD_LAT-1];
         if (r_rd_pipe[RD_LAT-1])
            r_rd_data <= ram_q;
      end
   end

`ifdef ARB_STATS_EN
   logic [15:0] r_stall_cnt;
   logic        r_ovf_seen;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_stall_cnt <= '0;
         r_ovf_seen  <= 1'b0;
      end else begin
         if (w_has_data && rd_en && (r_stall_cnt != 16'hFFFF))
            r_stall_cnt <= r_stall_cnt + 16'd1;
         if (wr_req && w_full)
            r_ovf_seen <= 1'b1;
      end
   end

   assign stall_cnt = r_stall_cnt;
   assign ovf_seen  = r_ovf_seen;
`endif

   assign ram_addr  = r_ram_addr;
   assign ram_we    = r_ram_we;
   assign ram_wdata = r_ram_wdata;
   assign wr_ack    = r_wr_ack;
   assign wr_full   = w_full;
   assign wr_empty  = w_empty;
   assign rd_valid  = r_rd_valid;
   assign rd_data   = r_rd_data;
   assign grant     = r_state;
endmodule

// File: tb/tb_vga_ram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_vga_ram_arbiter
// Randomised bench for vga_ram_arbiter with a queue-based reference model:
// the write buffer is a queue of accepted pixels, the RAM contents a shadow
// array updated in the order writes reach the RAM port, and each display
// read expects the shadow value at issue time, RD_LAT cycles later.
// Build with ARB_STATS_EN defined to also check stall_cnt / ovf_seen.
// ---------------------------------------------------------------------------
module tb_vga_ram_arbiter;
   localparam int AW    = 15;
   localparam int DW    = 6;
   localparam int DEPTH = 4;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          rd_en;
   logic [AW-1:0] rd_addr;
   logic [DW-1:0] rd_data;
   logic          rd_valid;
   logic          wr_req;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;
   logic          wr_ack;
   logic          wr_full;
   logic          wr_empty;
   logic [AW-1:0] ram_addr;
   logic          ram_we;
   logic [DW-1:0] ram_wdata;
   logic [DW-1:0] ram_q;
   logic [1:0]    grant;
`ifdef ARB_STATS_EN
   logic [15:0]   stall_cnt;
   logic          ovf_seen;
`endif

   vga_ram_arbiter #(
      .ADDR_W     (AW),
      .DATA_W     (DW),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .rd_en     (rd_en),
      .rd_addr   (rd_addr),
      .rd_data   (rd_data),
      .rd_valid  (rd_valid),
      .wr_req    (wr_req),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .wr_ack    (wr_ack),
      .wr_full   (wr_full),
      .wr_empty  (wr_empty),
      .ram_addr  (ram_addr),
      .ram_we    (ram_we),
      .ram_wdata (ram_wdata),
      .ram_q     (ram_q),
      .grant     (grant)
`ifdef ARB_STATS_EN
      ,
      .stall_cnt (stall_cnt),
      .ovf_seen  (ovf_seen)
`endif
   );

   always #20 clk = ~clk;

   // Power-on RAM content: each word holds the low bits of its address.
   function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
      return a[DW-1:0];
   endfunction

   // Synchronous single-port RAM, read-first, 1-cycle read latency.
   logic [DW-1:0] mem     [0:(1<<AW)-1];
   bit            mem_wr  [0:(1<<AW)-1];
   always @(posedge clk) begin
      ram_q <= mem_wr[ram_addr] ? mem[ram_addr] : init_val(ram_addr);
      if (ram_we) begin
         mem[ram_addr]    <= ram_wdata;
         mem_wr[ram_addr] <= 1'b1;
      end
   end

   // ------------------------------------------------------------------
   // Scoreboard state
   // ------------------------------------------------------------------
   typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; } wr_t;
   typedef struct { int due; logic [AW-1:0] a; logic [DW-1:0] d; } rd_t;

   wr_t           wq[$];
   rd_t           rq[$];
   logic [DW-1:0] shadow    [0:(1<<AW)-1];
   bit            shadow_wr [0:(1<<AW)-1];

   int            n_tests = 0;
   int            n_fail  = 0;
   int            cyc     = 0;
   int            n_wr    = 0;
   int            n_rd    = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s cyc=%0d got=%0h expected=%0h", nm, cyc, act, exp);
      end
   endtask

   // Inputs as seen by the DUT at the most recent rising edge.
   logic          s_rst_n = 1'b0;
   logic          s_rd_en, s_wr_req;
   logic [AW-1:0] s_rd_addr, s_wr_addr;
   logic [DW-1:0] s_wr_data;
   always @(posedge clk) begin
      s_rst_n   <= reset_n;
      s_rd_en   <= rd_en;
      s_rd_addr <= rd_addr;
      s_wr_req  <= wr_req;
      s_wr_addr <= wr_addr;
      s_wr_data <= wr_data;
   end

   // Reference-model state
   int            m_sz;
   bit            m_we, m_ack;
   logic [1:0]    m_gnt;
   logic [AW-1:0] m_addr  = '0;
   logic [DW-1:0] m_wdata = '0;
   int            m_stall = 0;
   bit            m_ovf   = 1'b0;
   wr_t           w_e;
   rd_t           r_e;

   always @(negedge clk) begin
      if (!reset_n) begin
         chk("rst_ram_we",    32'(ram_we),    32'd0);
         chk("rst_ram_addr",  32'(ram_addr),  32'd0);
         chk("rst_ram_wdata", 32'(ram_wdata), 32'd0);
         chk("rst_rd_valid",  32'(rd_valid),  32'd0);
         chk("rst_rd_data",   32'(rd_data),   32'd0);
         chk("rst_wr_ack",    32'(wr_ack),    32'd0);
         chk("rst_wr_full",   32'(wr_full),   32'd0);
         chk("rst_wr_empty",  32'(wr_empty),  32'd1);
         chk("rst_grant",     32'(grant),     32'd0);
`ifdef ARB_STATS_EN
         chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
         chk("rst_ovf_seen",  32'(ovf_seen),  32'd0);
`endif
         wq.delete();
         rq.delete();
         m_addr  = '0;
         m_wdata = '0;
         m_stall = 0;
         m_ovf   = 1'b0;
      end else if (s_rst_n) begin
         cyc++;
         m_sz  = wq.size();
         m_we  = !s_rd_en && (m_sz > 0);
         m_ack = s_wr_req && (m_sz < DEPTH);
         if (m_sz > 0 && s_rd_en && m_stall < 65535) m_stall++;
         if (s_wr_req && m_sz == DEPTH) m_ovf = 1'b1;

         if (s_rd_en) begin
            m_gnt  = 2'd1;
            m_addr = s_rd_addr;
            r_e.due = cyc + 2;
            r_e.a   = s_rd_addr;
            r_e.d   = shadow_wr[s_rd_addr] ? shadow[s_rd_addr] : init_val(s_rd_addr);
            rq.push_back(r_e);
         end else if (m_we) begin
            m_gnt   = 2'd2;
            w_e     = wq.pop_front();
            m_addr  = w_e.a;
            m_wdata = w_e.d;
            shadow[w_e.a]    = w_e.d;
            shadow_wr[w_e.a] = 1'b1;
         end else begin
            m_gnt = 2'd0;
         end
         if (m_ack) begin
            w_e.a = s_wr_addr;
            w_e.d = s_wr_data;
            wq.push_back(w_e);
         end

         chk("ram_we",   32'(ram_we),   32'(m_we));
         chk("ram_addr", 32'(ram_addr), 32'(m_addr));
         chk("grant",    32'(grant),    32'(m_gnt));
         chk("wr_ack",   32'(wr_ack),   32'(m_ack));
         chk("wr_full",  32'(wr_full),  32'(wq.size() == DEPTH));
         chk("wr_empty", 32'(wr_empty), 32'(wq.size() == 0));
         if (m_we) begin
            chk("ram_wdata", 32'(ram_wdata), 32'(m_wdata));
            n_wr++;
            $display("[TB] cyc=%0d RAM write addr=%0d data=%0h", cyc, m_addr, m_wdata);
         end
`ifdef ARB_STATS_EN
         chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
         chk("ovf_seen",  32'(ovf_seen),  32'(m_ovf));
`endif

         if (rq.size() > 0 && rq[0].due == cyc) begin
            r_e = rq.pop_front();
            chk("rd_valid", 32'(rd_valid), 32'd1);
            chk("rd_data",  32'(rd_data),  32'(r_e.d));
            n_rd++;
            $display("[TB] cyc=%0d read return addr=%0d data=%0h", cyc, r_e.a, rd_data);
         end else begin
            chk("rd_valid_idle", 32'(rd_valid), 32'd0);
         end
      end
   end

   // ------------------------------------------------------------------
   // Stimulus
   // ------------------------------------------------------------------
   // One clock of stimulus. The writer keeps its pixel on the bus until it
   // sees wr_ack, then drops wr_req; a new pixel may be offered next call.
   task automatic step(input logic ren, input logic [AW-1:0] raddr,
                       input bit want_wr, input logic [AW-1:0] waddr,
                       input logic [DW-1:0] wdata);
      rd_en   = ren;
      rd_addr = raddr;
      if (!wr_req && want_wr) begin
         wr_req  = 1'b1;
         wr_addr = waddr;
         wr_data = wdata;
      end
      @(posedge clk);
      #1;
      if (wr_req && wr_ack) wr_req = 1'b0;
   endtask

   task automatic rand_step(input logic ren, input bit want_wr);
      step(ren, AW'($urandom_range(0, 31)), want_wr,
           AW'($urandom_range(0, 31)), DW'($urandom_range(0, 63)));
   endtask

   task automatic do_reset(input int cycles);
      reset_n = 1'b0;
      wr_req  = 1'b0;
      rd_en   = 1'b1;
      repeat (cycles) @(posedge clk);
      #1;
      reset_n = 1'b1;
   endtask

   int mode, len;

   initial begin
      reset_n = 1'b0;
      rd_en   = 1'b0;
      rd_addr = '0;
      wr_req  = 1'b0;
      wr_addr = '0;
      wr_data = '0;
      repeat (3) @(posedge clk);
      #1;
      reset_n = 1'b1;

      // Idle after reset, then an 8-read burst of addresses 0..7.
      for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0, '0, '0);
      for (int i = 0; i < 8; i++) step(1'b1, AW'(i), 1'b0, '0, '0);
      for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b0, '0, '0);

      // Single write in blanking.
      step(1'b0, '0, 1'b1, AW'(100), 6'h2A);
      for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b0, '0, '0);

      // Continuous reads while five pixels are offered: buffer fills,
      // fifth pixel waits, then everything drains once reads stop.
      for (int i = 0; i < 14; i++)
         step(1'b1, AW'(i), 1'b1, AW'(200 + i), DW'(i + 1));
      for (int i = 0; i < 12; i++) step(1'b0, '0, (i < 3), AW'(300 + i), DW'(40 + i));

      // Read-after-write hazard on the same address: read sees old data.
      step(1'b0, '0, 1'b1, AW'(5), 6'h3F);
      step(1'b1, AW'(5), 1'b0, '0, '0);
      step(1'b1, AW'(5), 1'b0, '0, '0);
      for (int i = 0; i < 4; i++) step(1'b0, AW'(5), 1'b0, '0, '0);

      // Randomised active/blanking phases with a mid-stream reset.
      for (int ph = 0; ph < 50; ph++) begin
         if (ph == 25) do_reset(3);
         mode = $urandom_range(0, 2);
         len  = $urandom_range(3, 25);
         for (int k = 0; k < len; k++) begin
            case (mode)
               0:       rand_step(1'b1, $urandom_range(0, 3) != 0);
               1:       rand_step(1'b0, $urandom_range(0, 3) != 0);
               default: rand_step(1'($urandom_range(0, 1)), $urandom_range(0, 1) != 0);
            endcase
         end
      end

      // Drain: no reads, no new pixels, so everything must commit.
      for (int i = 0; i < 12; i++) step(1'b0, '0, 1'b0, '0, '0);
      @(negedge clk);
      chk("drain_wr_queue", 32'(wq.size()), 32'd0);
      chk("drain_rd_queue", 32'(rq.size()), 32'd0);
      chk("drain_wr_empty", 32'(wr_empty), 32'd1);
      chk("writes_seen",    32'(n_wr > 4), 32'd1);
      chk("reads_seen",     32'(n_rd > 8), 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
